// File: rtl/timer_psc.sv
// timer_psc: count-clock source and prescaler for the apb4_timer counter.
//   Picks either every clk_i cycle or every RTC rising edge as the count event,
//   divides the event stream by (shadow+1) and emits a one-cycle tick_o.
//   rtc_clk_i is only ever sampled; clk_i is the sole clock.
// Ports:
//   clk_i       system clock
//   rst_n_i     synchronous active-low reset
//   en_i        prescaler enable
//   clk_sel_i   0: internal clk_i events, 1: RTC rising edges
//   rtc_clk_i   asynchronous RTC input
//   psc_i       divide ratio minus one
//   psc_upd_i   one-cycle pulse: reload shadow from psc_i and clear the count
//   tick_o      one-cycle count enable to the timer counter
//   rtc_edge_o  one-cycle pulse per detected RTC rising edge
//   psc_cnt_o   current prescaler count
module timer_psc #(
  parameter int PSC_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 clk_sel_i,
  input  logic                 rtc_clk_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic                 psc_upd_i,
  output logic                 tick_o,
  output logic                 rtc_edge_o,
  output logic [PSC_WIDTH-1:0] psc_cnt_o
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PRIME_W-1:0]     prime_q;
  logic                   primed;
  logic                   rise;
  logic                   evt;
  logic [PSC_WIDTH-1:0]   cnt_q;
  logic [PSC_WIDTH-1:0]   shadow_q;
  logic                   clk_sel_q;

  // The chain is only trustworthy once the zeros loaded by reset have been
  // flushed through it; until then a high rtc_clk_i would look like an edge.
  assign primed = (prime_q == PRIME_MAX);
  assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

  // RTC synchronizer and edge detect; runs independently of en_i so that
  // re-enabling never sees a stale edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      prime_q    <= '0;
      rtc_edge_o <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rtc_clk_i};
      prev_q     <= sync_q[SYNC_STAGES-1];
      if (!primed) prime_q <= prime_q + PRIME_W'(1);
      rtc_edge_o <= rise & primed;
    end
  end

  assign evt = clk_sel_i ? rtc_edge_o : 1'b1;

  // Prescaler counter. A source switch is treated like an explicit update so
  // a partial period from the old source never leaks into the new one.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      tick_o    <= 1'b0;
      clk_sel_q <= 1'b0;
    end else begin
      clk_sel_q <= clk_sel_i;
      if (psc_upd_i || (clk_sel_i != clk_sel_q)) begin
        cnt_q    <= '0;
        shadow_q <= psc_i;
        tick_o   <= 1'b0;
      end else if (!en_i) begin
        cnt_q  <= '0;
        tick_o <= 1'b0;
      end else if (evt && (cnt_q == shadow_q)) begin
        cnt_q    <= '0;
        shadow_q <= psc_i;
        tick_o   <= 1'b1;
      end else if (evt) begin
        cnt_q  <= cnt_q + PSC_WIDTH'(1);
        tick_o <= 1'b0;
      end else begin
        tick_o <= 1'b0;
      end
    end
  end

  assign psc_cnt_o = cnt_q;

endmodule

// File: tb/tb_timer_psc.sv
module tb_timer_psc;
  localparam int PW = 16;
  localparam int EW = PW + 2;

  logic          clk = 1'b0;
  logic          rst_n, en, clk_sel, rtc, upd;
  logic [PW-1:0] psc;
  logic          tick, rtc_edge;
  logic [PW-1:0] cnt;

  int pass_cnt = 0;
  int total    = 0;

  // expected {tick_o, rtc_edge_o, psc_cnt_o}, pushed when stimulus is driven
  logic [EW-1:0] sb[$];
  logic [EW-1:0] exp_v, obs_v;

  timer_psc #(.PSC_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clk_sel_i(clk_sel),
    .rtc_clk_i(rtc), .psc_i(psc), .psc_upd_i(upd),
    .tick_o(tick), .rtc_edge_o(rtc_edge), .psc_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] mk(input logic t, input logic e, input int c);
    return {t, e, PW'(c)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clk_sel = 1'b0; rtc = 1'b0; upd = 1'b0; psc = '0;
    sb.push_back(mk(0, 0, 0));
    step(); step();
    exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
    total++;
    if (obs_v !== exp_v) $display("FAIL reset: got %h want %h", obs_v, exp_v);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_div1();
    en = 1'b0; psc = 0; upd = 1'b1; step(); upd = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(mk(1, 0, 0));
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL div1 cyc%0d: got %h want %h", k, obs_v, exp_v);
      else pass_cnt++;
    end
    en = 1'b0; step();
  endtask

  task automatic test_div4();
    psc = 3; upd = 1'b1; step(); upd = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back(mk((k % 4) == 0, 0, k % 4));
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL div4 cyc%0d: got %h want %h", k, obs_v, exp_v);
      else pass_cnt++;
    end
    en = 1'b0; step();
  endtask

  task automatic test_shadow();
    // expected count after each edge; tick where the count wraps to 0 from the period end
    int ec[16] = '{1,2,3,0,1,0,1,0, 0,1,2,0, 1,2,3,0};
    bit et[16] = '{0,0,0,1,0,1,0,1, 0,0,0,0, 0,0,0,1};
    psc = 3; upd = 1'b1; step(); upd = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      upd = 1'b0;
      if (k == 2)  psc = 1;               // no update: old period completes
      if (k == 9)  begin psc = 3; upd = 1'b1; end
      if (k == 12) upd = 1'b1;            // forced reload mid-count
      sb.push_back(mk(et[k-1], 0, ec[k-1]));
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL shadow cyc%0d: got %h want %h", k, obs_v, exp_v);
      else pass_cnt++;
    end
    upd = 1'b0; en = 1'b0; step();
  endtask

  task automatic test_enable_sel();
    int ec[15] = '{1,2,0,1,2,3,0,1,2,0,0,0,1,2,0};
    bit et[15] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,1};
    psc = 3; upd = 1'b1; step(); upd = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      en = (k != 3);
      if (k == 10) begin clk_sel = 1'b1; psc = 2; end
      if (k == 12) clk_sel = 1'b0;
      sb.push_back(mk(et[k-1], 0, ec[k-1]));
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL en_sel cyc%0d: got %h want %h", k, obs_v, exp_v);
      else pass_cnt++;
    end
    en = 1'b0; step();
  endtask

  task automatic test_rtc();
    rtc = 1'b0; repeat (4) step();
    clk_sel = 1'b1; psc = 1; upd = 1'b1; en = 1'b1; step(); upd = 1'b0;
    for (int j = 0; j < 40; j++) begin
      int c;
      rtc = (j % 5) < 3;   // 5-cycle RTC period, rising before edge j%5==0
      c = (j < 3) ? 0 : ((((j - 3) / 5) % 2) == 0 ? 1 : 0);
      sb.push_back(mk((j >= 8) && (((j - 8) % 10) == 0), (j % 5) == 2, c));
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL rtc cyc%0d: got %h want %h", j, obs_v, exp_v);
      else pass_cnt++;
    end
    rtc = 1'b0; en = 1'b0; clk_sel = 1'b0; step(); step();
  endtask

  task automatic test_reset_mid();
    psc = 3; upd = 1'b1; step(); upd = 1'b0;
    en = 1'b1; step(); step();           // cnt mid-period
    rtc = 1'b1; step();
    rst_n = 1'b0;
    sb.push_back(mk(0, 0, 0));
    step();
    exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
    total++;
    if (obs_v !== exp_v) $display("FAIL rst_mid: got %h want %h", obs_v, exp_v);
    else pass_cnt++;
    step();
    // release with RTC held high: no edge may be reported
    en = 1'b0; clk_sel = 1'b1;
    rst_n = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j == 8) rtc = 1'b0;
      if (j == 11) rtc = 1'b1;
      sb.push_back({1'b0, (j == 13), PW'(0)});
      step();
      exp_v = sb.pop_front(); obs_v = {tick, rtc_edge, cnt};
      total++;
      if (obs_v !== exp_v) $display("FAIL rst_rtc_hi cyc%0d: got %h want %h", j, obs_v, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div4();
    test_shadow();
    test_enable_sel();
    test_rtc();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
